oled_bounce: RTL and testbench

- Pixel source for the colour OLED driver (96x64, RGB565). Connects directly to the driver's pixel request port: read/row_idx/column_idx in, data_rgb/ack out.
- Renders a solid square sprite over a constant background. The sprite moves once every FRAME_DIV frames and bounces off the panel edges.
- Sprite colour advances through a 4-entry palette on every bounce.
- Serves as the animated test-pattern stage in place of static pattern generators.

---
 rtl/oled_bounce.sv | 142 ++++++++++++++
 tb/tb_oled_bounce.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/oled_bounce.sv
// Animated pixel source for the 96x64 RGB565 OLED driver: a solid square sprite
// bounces off the panel edges, changing palette colour on every bounce.
module oled_bounce #(
  parameter int          WIDTH     = 96,
  parameter int          HEIGHT    = 64,
  parameter int          SIZE      = 8,
  parameter int          STEP      = 1,
  parameter int          FRAME_DIV = 2,
  parameter logic [15:0] BG        = 16'h0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        read,
  input  logic [5:0]  row_idx,
  input  logic [6:0]  column_idx,
  output logic [15:0] data_rgb,
  output logic        ack
);

  localparam int         FW     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [7:0] SIZE8  = 8'(SIZE);
  localparam logic [7:0] STEP8  = 8'(STEP);
  localparam logic [7:0] XMAX   = 8'(WIDTH - SIZE);
  localparam logic [7:0] YMAX   = 8'(HEIGHT - SIZE);
  localparam logic [7:0] W8     = 8'(WIDTH);
  localparam logic [7:0] H8     = 8'(HEIGHT);
  localparam logic [7:0] WLAST  = 8'(WIDTH - 1);
  localparam logic [7:0] HLAST  = 8'(HEIGHT - 1);
  localparam logic [FW-1:0] FLAST = FW'(FRAME_DIV - 1);

  // Returns {bounced, new_position}; the clamp may move less than STEP on a bounce.
  function automatic logic [8:0] step_axis(input logic [7:0] pos, input logic neg,
                                           input logic [7:0] lim);
    logic [8:0] res;
    if (!neg) begin
      if (pos + STEP8 > lim) res = {1'b1, lim};
      else                   res = {1'b0, pos + STEP8};
    end else begin
      if (pos < STEP8) res = {1'b1, 8'd0};
      else             res = {1'b0, pos - STEP8};
    end
    return res;
  endfunction

  function automatic logic [15:0] palette(input logic [1:0] idx);
    logic [15:0] c;
    case (idx)
      2'd0:    c = 16'hF800;
      2'd1:    c = 16'h07E0;
      2'd2:    c = 16'h001F;
      default: c = 16'hFFFF;
    endcase
    return c;
  endfunction

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [6:0]    x;
  logic [5:0]    y;
  logic          dx_neg, dy_neg;
  logic [1:0]    col_idx;
  logic [FW-1:0] frame_cnt;

  logic          vld_p0;
  logic [5:0]    row_p0;
  logic [6:0]    col_p0;
  logic          last_p1;

  logic          accept;
  logic [7:0]    c8, r8, x8, y8;
  logic          inside_p0, last_p0;
  logic [8:0]    nx, ny;

  // A request in flight (capture stage or ack cycle) blocks new reads.
  assign accept = read && !vld_p0 && !ack;

  // Stage p0: capture request coordinates
  always_ff @(posedge clk) begin
    if (accept) begin
      row_p0 <= row_idx;
      col_p0 <= column_idx;
    end
  end

  // 8-bit intermediates keep x+SIZE from wrapping.
  assign c8 = {1'b0, col_p0};
  assign r8 = {2'b00, row_p0};
  assign x8 = {1'b0, x};
  assign y8 = {2'b00, y};

  assign inside_p0 = (c8 < W8) && (r8 < H8) &&
                     (c8 >= x8) && (c8 < x8 + SIZE8) &&
                     (r8 >= y8) && (r8 < y8 + SIZE8);
  assign last_p0   = (r8 == HLAST) && (c8 == WLAST);

  assign nx = step_axis(x8, dx_neg, XMAX);
  assign ny = step_axis(y8, dy_neg, YMAX);

  // Stage p1: colour registered, ack driven; frame-end update on the ack cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      ack       <= 1'b0;
      data_rgb  <= 16'h0000;
      last_p1   <= 1'b0;
      x         <= '0;
      y         <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      col_idx   <= 2'd0;
      frame_cnt <= '0;
    end else begin
      vld_p0 <= accept;
      ack    <= vld_p0;
      if (vld_p0) begin
        data_rgb <= inside_p0 ? palette(col_idx) : BG;
        last_p1  <= last_p0;
      end
      if (ack && last_p1) begin
        if (frame_cnt == FLAST) begin
          frame_cnt <= '0;
          x         <= 7'(nx[7:0]);
          y         <= 6'(ny[7:0]);
          dx_neg    <= dx_neg ^ nx[8];
          dy_neg    <= dy_neg ^ ny[8];
          if (nx[8] || ny[8]) col_idx <= col_idx + 2'd1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_bounce.sv
// Directed bench for oled_bounce: default 96x64 instance plus a 64x64 instance
// where both axes bounce on the same update.
module tb_oled_bounce;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        read_a = 1'b0, read_b = 1'b0;
  logic [5:0]  row_a = '0, row_b = '0;
  logic [6:0]  col_a = '0, col_b = '0;
  logic [15:0] data_a, data_b;
  logic        ack_a, ack_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oled_bounce dut_a (
    .clk(clk), .resetn(resetn), .read(read_a), .row_idx(row_a),
    .column_idx(col_a), .data_rgb(data_a), .ack(ack_a)
  );

  oled_bounce #(.WIDTH(64), .HEIGHT(64), .FRAME_DIV(1)) dut_b (
    .clk(clk), .resetn(resetn), .read(read_b), .row_idx(row_b),
    .column_idx(col_b), .data_rgb(data_b), .ack(ack_b)
  );

  task automatic chk(input logic [15:0] got, input logic [15:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [5:0] r, input logic [6:0] c);
    if (sel) begin read_b = v; row_b = r; col_b = c; end
    else     begin read_a = v; row_a = r; col_a = c; end
  endtask

  function automatic logic [15:0] ack_of(input bit sel);
    return {15'd0, sel ? ack_b : ack_a};
  endfunction

  function automatic logic [15:0] data_of(input bit sel);
    return sel ? data_b : data_a;
  endfunction

  // Full request: ack must appear exactly two cycles after the strobe, then drop.
  task automatic rd(input bit sel, input logic [5:0] r, input logic [6:0] c,
                    input logic [15:0] exp, input string tag);
    @(posedge clk); #1; drive(sel, 1'b1, r, c);
    @(posedge clk); #1; drive(sel, 1'b0, r, c);
    chk(ack_of(sel), 16'd0, {tag, "_ack_early"});
    @(posedge clk); #1;
    chk(ack_of(sel), 16'd1, {tag, "_ack"});
    chk(data_of(sel), exp, {tag, "_data"});
    @(posedge clk); #1;
    chk(ack_of(sel), 16'd0, {tag, "_ack_drop"});
    chk(data_of(sel), exp, {tag, "_hold"});
  endtask

  // Frame-end requests only; n of them end n frames.
  task automatic adv(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive(sel, 1'b1, 6'd63, sel ? 7'd63 : 7'd95);
      @(posedge clk); #1; drive(sel, 1'b0, 6'd0, 7'd0);
      @(posedge clk);
      @(posedge clk);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1; resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(ack_of(0), 16'd0, "rst_ack");
    chk(data_of(0), 16'h0000, "rst_data");

    rd(0, 6'd0, 7'd0,   16'hF800, "origin");
    rd(0, 6'd0, 7'd8,   16'h0000, "right_edge");
    rd(0, 6'd7, 7'd7,   16'hF800, "last_inside");
    rd(0, 6'd0, 7'd100, 16'h0000, "out_of_range");

    // Back-to-back reads: second one is dropped.
    @(posedge clk); #1; drive(0, 1'b1, 6'd0, 7'd0);
    @(posedge clk); #1;
    chk(ack_of(0), 16'd0, "dbl_n1");
    @(posedge clk); #1; drive(0, 1'b0, 6'd0, 7'd0);
    chk(ack_of(0), 16'd1, "dbl_ack");
    chk(data_of(0), 16'hF800, "dbl_data");
    @(posedge clk); #1;
    chk(ack_of(0), 16'd0, "dbl_no_second");
    @(posedge clk); #1;
    chk(ack_of(0), 16'd0, "dbl_no_second2");
    rd(0, 6'd0, 7'd8, 16'h0000, "after_dbl");

    // Frame 1 ends: no move yet.
    adv(0, 1);
    rd(0, 6'd0, 7'd0, 16'hF800, "f1_origin");
    rd(0, 6'd8, 7'd8, 16'h0000, "f1_outside");
    // Frame 2 ends: first update to (1,1).
    adv(0, 1);
    rd(0, 6'd1, 7'd1, 16'hF800, "u1_topleft");
    rd(0, 6'd0, 7'd0, 16'h0000, "u1_origin_bg");
    rd(0, 6'd8, 7'd8, 16'hF800, "u1_bottomright");

    // Update 87: x=87, y=26 (y bounced at update 57 -> colour 1).
    adv(0, 172);
    rd(0, 6'd26, 7'd87, 16'h07E0, "u87_in");
    rd(0, 6'd26, 7'd86, 16'h0000, "u87_left");
    adv(0, 2);
    rd(0, 6'd25, 7'd88, 16'h07E0, "u88_in");
    rd(0, 6'd25, 7'd95, 16'h07E0, "u88_lastcol");
    rd(0, 6'd25, 7'd87, 16'h0000, "u88_left");
    // Update 89: x clamps at 88 and bounces -> colour 2.
    adv(0, 2);
    rd(0, 6'd24, 7'd88, 16'h001F, "u89_bounce");
    rd(0, 6'd24, 7'd87, 16'h0000, "u89_left");
    adv(0, 2);
    rd(0, 6'd23, 7'd95, 16'h0000, "u90_right");
    rd(0, 6'd23, 7'd87, 16'h001F, "u90_in");

    // 64x64 instance: both axes reach 56 together, then bounce on one update.
    adv(1, 56);
    rd(1, 6'd56, 7'd56, 16'hF800, "b56_in");
    rd(1, 6'd55, 7'd56, 16'h0000, "b56_above");
    adv(1, 1);
    rd(1, 6'd56, 7'd56, 16'h07E0, "corner_colour");
    adv(1, 1);
    rd(1, 6'd55, 7'd55, 16'h07E0, "b58_in");
    rd(1, 6'd62, 7'd62, 16'h07E0, "b58_far");
    rd(1, 6'd54, 7'd55, 16'h0000, "b58_above");

    // Reset between request and ack: ack dropped, state back to origin.
    @(posedge clk); #1; drive(0, 1'b1, 6'd23, 7'd87);
    @(posedge clk); #1; drive(0, 1'b0, 6'd0, 7'd0);
    resetn = 1'b0;
    #1;
    chk(ack_of(0), 16'd0, "midrst_ack");
    chk(data_of(0), 16'h0000, "midrst_data");
    @(posedge clk); #1; resetn = 1'b1;
    chk(ack_of(0), 16'd0, "midrst_ack2");
    @(posedge clk); #1;
    chk(ack_of(0), 16'd0, "midrst_ack3");
    chk(data_of(0), 16'h0000, "midrst_data3");
    @(posedge clk); #1;
    rd(0, 6'd0, 7'd0, 16'hF800, "post_rst_origin");
    rd(0, 6'd8, 7'd8, 16'h0000, "post_rst_outside");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
